lsd_output_pingpong_buffer: RTL and testbench
=============================================

Name: lsd_output_pingpong_buffer

Overview:
Two-bank (ping-pong) capture buffer for line segments produced by simple_lsd, with frame-granular publish/lock handshake to the PS reader.
- One bank collects the current frame's segments while the other holds the last completed frame for readout.
- Adds write-overflow detection, dropped-frame accounting and a frame ID, none of which the single-bank buffer provides.
- Sits between simple_lsd and the PS register/AXI-lite read interface.

Parameters:
FRAME_HEIGHT, 525, vertical frame size; V_BITW = ceil(log2(FRAME_HEIGHT))
FRAME_WIDTH, 800, horizontal frame size; H_BITW = ceil(log2(FRAME_WIDTH))
RAM_SIZE, 4096, words per bank (power of two); ADDR_BITW = log2(RAM_SIZE)
WORD_SIZE, derived, 2*(H_BITW+V_BITW); not overridable

Ports:
wclock  in  1  clock, all logic
n_rst  in  1  synchronous active-low reset
in_flag  in  1  high while simple_lsd frame output is active
in_valid  in  1  segment on in_* valid this cycle (qualified by in_flag)
in_start_v  in  V_BITW  segment start row
in_start_h  in  H_BITW  segment start column
in_end_v  in  V_BITW  segment end row
in_end_h  in  H_BITW  segment end column
in_rd_lock  in  1  PS holds published bank (level)
in_rd_addr  in  ADDR_BITW  read address into published bank
out_ready  out  1  a published frame exists
out_line_num  out  ADDR_BITW+1  segment count of published frame
out_overflow  out  1  published frame exceeded RAM_SIZE segments
out_frame_id  out  16  published frame counter
out_drop_count  out  16  frames discarded due to lock
out_start_v, out_start_h, out_end_v, out_end_h  out  V/H_BITW  word at in_rd_addr in published bank

Behaviour:
Reset, synchronous on wclock, n_rst=0:
- wr_bank=0, pub_bank=1, wr_cnt=0, armed=0, flag_d=0.
- out_ready=0, out_line_num=0, out_overflow=0, out_frame_id=0, out_drop_count=0.
- RAM contents are not cleared; out_* data are undefined until the first publish.

Arming:
- armed is set on the first cycle in_flag=0 after reset.
- A frame already in progress at reset release is ignored entirely: no writes, no publish.

Write:
- Condition: armed & in_flag & in_valid & wr_cnt<RAM_SIZE.
- Action: bank[wr_bank][wr_cnt[ADDR_BITW-1:0]] <= {start_v,start_h,end_v,end_h}; wr_cnt++.
- If the condition holds except wr_cnt==RAM_SIZE: word dropped, wr_ovf<=1.
- wr_cnt saturates at RAM_SIZE (width ADDR_BITW+1).

Frame start:
- flag_d=0 & in_flag=1 & armed: wr_cnt<=0, wr_ovf<=0.
- The first-cycle in_valid is written at address 0 the same cycle; the clear and the write are merged.

Frame end:
- flag_d=1 & in_flag=0 & armed; the last high cycle's segment has already been written.
- If in_rd_lock=0:
  - pub_bank<=wr_bank; wr_bank<=~wr_bank.
  - out_line_num<=wr_cnt; out_overflow<=wr_ovf; out_ready<=1.
  - out_frame_id++ (wraps at 16 bits).
- If in_rd_lock=1:
  - Published state unchanged; wr_bank unchanged, so the next frame overwrites it.
  - out_drop_count++ (saturates at 0xFFFF).
- A zero-segment frame still publishes, with out_line_num=0.
- Lock is sampled only in the frame-end cycle. Lock asserted in that same cycle counts as locked. Lock release mid-frame takes effect at the next frame end.

Read:
- Synchronous, latency 1: out_* registered from bank[pub_bank][in_rd_addr].
- Addresses >= out_line_num return stale contents; no error is flagged.
- If pub_bank switches, the following cycle's read reflects the new bank. Coherent readout requires in_rd_lock=1.
- Read and write banks are always different; there is no read/write collision.

Test Plan:
- Reset, then frame with 3 valid segments, lock=0 -> at frame-end+1: out_ready=1, out_line_num=3, out_frame_id=1; addr 0..2 return the written words 1 cycle after addr.
- Lock=1, run 2 frames (5 and 7 segments) -> out_line_num stays 3, out_drop_count=2, reads unchanged. Release lock, run a 4-segment frame -> out_line_num=4, out_frame_id=2.
- RAM_SIZE=16, frame with 20 valid segments -> out_line_num=16, out_overflow=1, words 0..15 equal the first 16 inputs. Next frame with 2 segments -> out_overflow=0.
- in_flag high at reset release with valids -> no publish at its end (out_ready=0). Next full frame publishes normally.
- Empty frame (in_flag pulse, no valids) -> out_ready=1, out_line_num=0, out_frame_id increments. Valid on the last in_flag-high cycle is counted.
- n_rst asserted mid-frame after 2 writes -> all outputs return to reset values next cycle, and the rest of that frame is ignored.

Source files
------------

// File: rtl/lsd_output_pingpong_buffer.sv
// Two-bank segment capture buffer: one bank fills with the current frame while the other is published for readout.
// Read latency 1 cycle; no backpressure, so words past RAM_SIZE are dropped and flagged, and frames ending while the reader holds the lock are dropped and counted.
module lsd_output_pingpong_buffer #(
    parameter  int FRAME_HEIGHT = 525,
    parameter  int FRAME_WIDTH  = 800,
    parameter  int RAM_SIZE     = 4096,
    localparam int V_BITW       = $clog2(FRAME_HEIGHT),
    localparam int H_BITW       = $clog2(FRAME_WIDTH),
    localparam int ADDR_BITW    = $clog2(RAM_SIZE),
    localparam int WORD_SIZE    = 2 * (H_BITW + V_BITW)
) (
    input  logic                 wclock,
    input  logic                 n_rst,
    input  logic                 in_flag,
    input  logic                 in_valid,
    input  logic [V_BITW-1:0]    in_start_v,
    input  logic [H_BITW-1:0]    in_start_h,
    input  logic [V_BITW-1:0]    in_end_v,
    input  logic [H_BITW-1:0]    in_end_h,
    input  logic                 in_rd_lock,
    input  logic [ADDR_BITW-1:0] in_rd_addr,
    output logic                 out_ready,
    output logic [ADDR_BITW:0]   out_line_num,
    output logic                 out_overflow,
    output logic [15:0]          out_frame_id,
    output logic [15:0]          out_drop_count,
    output logic [V_BITW-1:0]    out_start_v,
    output logic [H_BITW-1:0]    out_start_h,
    output logic [V_BITW-1:0]    out_end_v,
    output logic [H_BITW-1:0]    out_end_h
);

    localparam int CNT_W = ADDR_BITW + 1;

    logic                 flag_d_q, flag_d_d;
    logic                 armed_q, armed_d;
    logic                 wr_bank_q, wr_bank_d;
    logic                 pub_bank_q, pub_bank_d;
    logic [CNT_W-1:0]     wr_cnt_q, wr_cnt_d;
    logic                 wr_ovf_q, wr_ovf_d;
    logic                 ready_q, ready_d;
    logic [CNT_W-1:0]     line_num_q, line_num_d;
    logic                 overflow_q, overflow_d;
    logic [15:0]          frame_id_q, frame_id_d;
    logic [15:0]          drop_count_q, drop_count_d;

    logic                 frame_start;
    logic                 frame_end;
    logic [CNT_W-1:0]     cnt_base;
    logic                 ovf_base;
    logic                 mem_we;
    logic [CNT_W-1:0]     mem_waddr;
    logic [CNT_W-1:0]     mem_raddr;
    logic [WORD_SIZE-1:0] mem_wdat;
    logic [WORD_SIZE-1:0] rd_dat_q;

    // Bank select is the address MSB: both banks live in one array.
    logic [WORD_SIZE-1:0] mem [0:2*RAM_SIZE-1];

    always_comb begin
        flag_d_d     = in_flag;
        armed_d      = armed_q | ~in_flag;
        wr_bank_d    = wr_bank_q;
        pub_bank_d   = pub_bank_q;
        ready_d      = ready_q;
        line_num_d   = line_num_q;
        overflow_d   = overflow_q;
        frame_id_d   = frame_id_q;
        drop_count_d = drop_count_q;

        frame_start = armed_q & ~flag_d_q & in_flag;
        frame_end   = armed_q & flag_d_q & ~in_flag;

        // The frame-start clear is merged with a first-cycle write.
        cnt_base = frame_start ? '0 : wr_cnt_q;
        ovf_base = frame_start ? 1'b0 : wr_ovf_q;
        wr_cnt_d = cnt_base;
        wr_ovf_d = ovf_base;

        mem_we    = 1'b0;
        mem_waddr = {wr_bank_q, cnt_base[ADDR_BITW-1:0]};
        mem_wdat  = {in_start_v, in_start_h, in_end_v, in_end_h};
        mem_raddr = {pub_bank_q, in_rd_addr};

        if (armed_q && in_flag && in_valid) begin
            // MSB set means the counter has saturated at RAM_SIZE.
            if (!cnt_base[ADDR_BITW]) begin
                mem_we   = 1'b1;
                wr_cnt_d = cnt_base + CNT_W'(1);
            end else begin
                wr_ovf_d = 1'b1;
            end
        end

        if (frame_end) begin
            if (!in_rd_lock) begin
                pub_bank_d = wr_bank_q;
                wr_bank_d  = ~wr_bank_q;
                line_num_d = wr_cnt_q;
                overflow_d = wr_ovf_q;
                ready_d    = 1'b1;
                frame_id_d = frame_id_q + 16'd1;
            end else if (drop_count_q != 16'hFFFF) begin
                drop_count_d = drop_count_q + 16'd1;
            end
        end
    end

    always_ff @(posedge wclock) begin
        if (!n_rst) begin
            flag_d_q     <= 1'b0;
            armed_q      <= 1'b0;
            wr_bank_q    <= 1'b0;
            pub_bank_q   <= 1'b1;
            wr_cnt_q     <= '0;
            wr_ovf_q     <= 1'b0;
            ready_q      <= 1'b0;
            line_num_q   <= '0;
            overflow_q   <= 1'b0;
            frame_id_q   <= 16'd0;
            drop_count_q <= 16'd0;
        end else begin
            flag_d_q     <= flag_d_d;
            armed_q      <= armed_d;
            wr_bank_q    <= wr_bank_d;
            pub_bank_q   <= pub_bank_d;
            wr_cnt_q     <= wr_cnt_d;
            wr_ovf_q     <= wr_ovf_d;
            ready_q      <= ready_d;
            line_num_q   <= line_num_d;
            overflow_q   <= overflow_d;
            frame_id_q   <= frame_id_d;
            drop_count_q <= drop_count_d;
        end
    end

    // Storage is deliberately not reset so it maps onto block RAM.
    always_ff @(posedge wclock) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdat;
        end
        rd_dat_q <= mem[mem_raddr];
    end

    assign out_ready      = ready_q;
    assign out_line_num   = line_num_q;
    assign out_overflow   = overflow_q;
    assign out_frame_id   = frame_id_q;
    assign out_drop_count = drop_count_q;
    assign {out_start_v, out_start_h, out_end_v, out_end_h} = rd_dat_q;

endmodule

// File: tb/tb_lsd_output_pingpong_buffer.sv
// Directed bench for lsd_output_pingpong_buffer with a 16-word bank so overflow is cheap to reach.
module tb_lsd_output_pingpong_buffer;

    localparam int V_BITW    = 10;
    localparam int H_BITW    = 10;
    localparam int ADDR_BITW = 4;

    logic                 wclock = 1'b0;
    logic                 n_rst;
    logic                 in_flag;
    logic                 in_valid;
    logic [V_BITW-1:0]    in_start_v;
    logic [H_BITW-1:0]    in_start_h;
    logic [V_BITW-1:0]    in_end_v;
    logic [H_BITW-1:0]    in_end_h;
    logic                 in_rd_lock;
    logic [ADDR_BITW-1:0] in_rd_addr;
    logic                 out_ready;
    logic [ADDR_BITW:0]   out_line_num;
    logic                 out_overflow;
    logic [15:0]          out_frame_id;
    logic [15:0]          out_drop_count;
    logic [V_BITW-1:0]    out_start_v;
    logic [H_BITW-1:0]    out_start_h;
    logic [V_BITW-1:0]    out_end_v;
    logic [H_BITW-1:0]    out_end_h;

    int n_chk = 0;
    int n_bad = 0;

    lsd_output_pingpong_buffer #(
        .FRAME_HEIGHT(525),
        .FRAME_WIDTH (800),
        .RAM_SIZE    (16)
    ) dut (
        .wclock        (wclock),
        .n_rst         (n_rst),
        .in_flag       (in_flag),
        .in_valid      (in_valid),
        .in_start_v    (in_start_v),
        .in_start_h    (in_start_h),
        .in_end_v      (in_end_v),
        .in_end_h      (in_end_h),
        .in_rd_lock    (in_rd_lock),
        .in_rd_addr    (in_rd_addr),
        .out_ready     (out_ready),
        .out_line_num  (out_line_num),
        .out_overflow  (out_overflow),
        .out_frame_id  (out_frame_id),
        .out_drop_count(out_drop_count),
        .out_start_v   (out_start_v),
        .out_start_h   (out_start_h),
        .out_end_v     (out_end_v),
        .out_end_h     (out_end_h)
    );

    always #5 wclock = ~wclock;

    // Segment k: start=(k+1, 2k+5), end=(k+100, 7k+9).
    function automatic logic [39:0] seg(input int k);
        logic [9:0] a, b, c, d;
        a = 10'(k + 1);
        b = 10'(k * 2 + 5);
        c = 10'(k + 100);
        d = 10'(k * 7 + 9);
        return {a, b, c, d};
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge wclock);
        #1;
    endtask

    task automatic drive_seg(input int k);
        {in_start_v, in_start_h, in_end_v, in_end_h} = seg(k);
    endtask

    task automatic send_frame(input int n, input logic lock, input int base);
        in_rd_lock = lock;
        in_flag    = 1'b0;
        in_valid   = 1'b0;
        tick();
        for (int i = 0; i < n; i++) begin
            in_flag  = 1'b1;
            in_valid = 1'b1;
            drive_seg(base + i);
            tick();
        end
        if (n == 0) begin
            in_flag  = 1'b1;
            in_valid = 1'b0;
            tick();
        end
        in_flag  = 1'b0;
        in_valid = 1'b0;
        tick();
    endtask

    task automatic read_chk(input string tag, input int addr, input int k);
        in_rd_addr = ADDR_BITW'(addr);
        tick();
        check(tag, 64'({out_start_v, out_start_h, out_end_v, out_end_h}), 64'(seg(k)));
    endtask

    task automatic status_chk(input string tag, input logic rdy, input int lines,
                              input logic ovf, input int fid, input int drops);
        check({tag, "_ready"}, 64'(out_ready), 64'(rdy));
        check({tag, "_lines"}, 64'(out_line_num), 64'(lines));
        check({tag, "_ovf"},   64'(out_overflow), 64'(ovf));
        check({tag, "_id"},    64'(out_frame_id), 64'(fid));
        check({tag, "_drop"},  64'(out_drop_count), 64'(drops));
    endtask

    initial begin
        n_rst      = 1'b0;
        in_flag    = 1'b1;
        in_valid   = 1'b1;
        in_rd_lock = 1'b0;
        in_rd_addr = '0;
        drive_seg(90);
        tick();
        tick();
        status_chk("reset", 1'b0, 0, 1'b0, 0, 0);

        // Frame already running at reset release must be ignored.
        n_rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_seg(90 + i);
            tick();
        end
        in_flag  = 1'b0;
        in_valid = 1'b0;
        tick();
        check("partial_ready", 64'(out_ready), 64'd0);

        send_frame(3, 1'b0, 0);
        status_chk("f3", 1'b1, 3, 1'b0, 1, 0);
        read_chk("f3_a0", 0, 0);
        read_chk("f3_a1", 1, 1);
        read_chk("f3_a2", 2, 2);

        send_frame(5, 1'b1, 10);
        send_frame(7, 1'b1, 20);
        status_chk("locked", 1'b1, 3, 1'b0, 1, 2);
        read_chk("locked_a0", 0, 0);
        read_chk("locked_a2", 2, 2);

        send_frame(4, 1'b0, 40);
        status_chk("f4", 1'b1, 4, 1'b0, 2, 2);
        read_chk("f4_a0", 0, 40);
        read_chk("f4_a3", 3, 43);

        send_frame(20, 1'b0, 60);
        status_chk("ovf", 1'b1, 16, 1'b1, 3, 2);
        for (int a = 0; a < 16; a++) begin
            read_chk($sformatf("ovf_a%0d", a), a, 60 + a);
        end

        send_frame(2, 1'b0, 100);
        status_chk("f2", 1'b1, 2, 1'b0, 4, 2);
        read_chk("f2_a1", 1, 101);

        send_frame(0, 1'b0, 0);
        status_chk("empty", 1'b1, 0, 1'b0, 5, 2);

        // Reset in the middle of a frame after two writes.
        in_flag  = 1'b0;
        in_valid = 1'b0;
        tick();
        in_flag  = 1'b1;
        in_valid = 1'b1;
        drive_seg(110);
        tick();
        drive_seg(111);
        tick();
        n_rst = 1'b0;
        drive_seg(112);
        tick();
        status_chk("midrst", 1'b0, 0, 1'b0, 0, 0);
        n_rst = 1'b1;
        drive_seg(113);
        tick();
        drive_seg(114);
        tick();
        in_flag  = 1'b0;
        in_valid = 1'b0;
        tick();
        check("midrst_ignored", 64'(out_ready), 64'd0);

        send_frame(1, 1'b0, 120);
        status_chk("after_rst", 1'b1, 1, 1'b0, 1, 0);
        read_chk("after_rst_a0", 0, 120);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
